// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder
//   Reverse path of the two-digit 7-segment display driver. Samples the tens
//   and units segment lines, waits until they have been stable for
//   STABLE_CYCLES synchronized samples, and decodes them back to BCD digits
//   and a binary value 0..99. Each distinct stable pattern is reported once
//   over a valid/ready handshake.
//
// Parameters
//   STABLE_CYCLES  identical consecutive samples required before capture (>=1)
//   ACTIVE_LOW     1: segment inputs are active-low; 0: active-high
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   seg1_in   tens digit segments {g,f,e,d,c,b,a}
//   seg2_in   units digit segments {g,f,e,d,c,b,a}
//   ready     consumer accepts the current result
//   valid     result available; held until ready
//   data_out  tens*10+ones (0..99); 0 on err or blank
//   tens_out  decoded tens digit; 4'hF on err
//   ones_out  decoded units digit; 4'hF on err
//   err       result contains an illegal pattern
//   blank     both digits dark
module sevenseg_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg1_in,
  input  logic [6:0] seg2_in,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data_out,
  output logic [3:0] tens_out,
  output logic [3:0] ones_out,
  output logic       err,
  output logic       blank
);

  localparam int              CNT_W    = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  // All-dark pattern as it appears on the raw pins.
  localparam logic [13:0]     DARK_RAW = ACTIVE_LOW ? 14'h3FFF : 14'h0000;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_EMIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_ARMED = 2'd3
  } state_t;

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] data;
  } result_t;

  // Returns {legal, dark, digit}. Dark counts as legal here; the digit
  // combination rules decide what a dark position means.
  function automatic logic [5:0] decode_digit(input logic [6:0] seg);
    case (seg)
      7'h3F:   decode_digit = {2'b10, 4'd0};
      7'h06:   decode_digit = {2'b10, 4'd1};
      7'h5B:   decode_digit = {2'b10, 4'd2};
      7'h4F:   decode_digit = {2'b10, 4'd3};
      7'h66:   decode_digit = {2'b10, 4'd4};
      7'h6D:   decode_digit = {2'b10, 4'd5};
      7'h7D:   decode_digit = {2'b10, 4'd6};
      7'h07:   decode_digit = {2'b10, 4'd7};
      7'h7F:   decode_digit = {2'b10, 4'd8};
      7'h6F:   decode_digit = {2'b10, 4'd9};
      7'h00:   decode_digit = {2'b11, 4'd0};
      default: decode_digit = {2'b00, 4'hF};
    endcase
  endfunction

  // Combines both digit decodes; rule order matters (illegal beats blank,
  // blank beats the dark-position rules).
  function automatic result_t resolve(input logic [6:0] tens_seg,
                                      input logic [6:0] ones_seg);
    logic [5:0] t;
    logic [5:0] o;
    logic [7:0] t8;
    t       = decode_digit(tens_seg);
    o       = decode_digit(ones_seg);
    resolve = '0;
    if (!t[5] || !o[5]) begin
      resolve.err  = 1'b1;
      resolve.tens = 4'hF;
      resolve.ones = 4'hF;
    end else if (t[4] && o[4]) begin
      resolve.blank = 1'b1;
    end else if (o[4]) begin
      // A lit tens digit over a dark units digit is never a valid number.
      resolve.err  = 1'b1;
      resolve.tens = 4'hF;
      resolve.ones = 4'hF;
    end else begin
      // Dark tens with a legal units digit is a suppressed leading zero.
      resolve.tens = t[4] ? 4'd0 : t[3:0];
      resolve.ones = o[3:0];
      t8           = {4'd0, resolve.tens};
      resolve.data = (t8 << 3) + (t8 << 1) + {4'd0, resolve.ones};
    end
  endfunction

  logic [13:0]      seg_p0;
  logic [13:0]      seg_p1;
  logic [13:0]      pat_p1;
  logic [13:0]      prev_p2;
  logic [13:0]      cap_p2;
  logic             have_cap;
  logic [CNT_W-1:0] cnt;
  logic             stable;
  result_t          res_p1;

  state_t state;
  state_t state_nxt;
  logic   load_res;
  logic   drop_vld;
  logic   clr_cnt;

  // ---- stage p0/p1: two-flop synchronizer on the raw pins ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p0 <= DARK_RAW;
      seg_p1 <= DARK_RAW;
    end else begin
      seg_p0 <= {seg1_in, seg2_in};
      seg_p1 <= seg_p0;
    end
  end

  // Normalised to active-high {tens, units}.
  assign pat_p1 = ACTIVE_LOW ? ~seg_p1 : seg_p1;
  assign stable = (pat_p1 == prev_p2);
  assign res_p1 = resolve(pat_p1[13:7], pat_p1[6:0]);

  // ---- stage p2: previous sample and stability counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p2 <= 14'h0000;
      cnt     <= '0;
    end else begin
      prev_p2 <= pat_p1;
      if (clr_cnt || !stable) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    drop_vld  = 1'b0;
    clr_cnt   = 1'b0;
    case (state)
      S_WAIT: begin
        if ((cnt == CNT_MAX) && stable) begin
          // A pattern that settles back to the one last reported (e.g. after
          // a short glitch) is not reported a second time.
          if (have_cap && (pat_p1 == cap_p2)) begin
            state_nxt = S_ARMED;
          end else begin
            state_nxt = S_EMIT;
            load_res  = 1'b1;
          end
        end
      end
      S_EMIT, S_HOLD: begin
        if (ready) begin
          state_nxt = S_ARMED;
          drop_vld  = 1'b1;
        end else begin
          state_nxt = S_HOLD;
        end
      end
      S_ARMED: begin
        if (pat_p1 != cap_p2) begin
          state_nxt = S_WAIT;
          clr_cnt   = 1'b1;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // ---- stage p3: captured result and handshake ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      err      <= 1'b0;
      blank    <= 1'b0;
      tens_out <= 4'd0;
      ones_out <= 4'd0;
      data_out <= 8'd0;
      cap_p2   <= 14'h0000;
      have_cap <= 1'b0;
    end else if (load_res) begin
      valid    <= 1'b1;
      err      <= res_p1.err;
      blank    <= res_p1.blank;
      tens_out <= res_p1.tens;
      ones_out <= res_p1.ones;
      data_out <= res_p1.data;
      cap_p2   <= pat_p1;
      have_cap <= 1'b1;
    end else if (drop_vld) begin
      valid <= 1'b0;
    end
  end

endmodule
